// File: rtl/stepper_motor_pkg.sv
// Shared types and constants for the stepper microstep driver: winding sign encoding,
// quadrant codes and the elaboration-time quarter-sine generator.
package stepper_motor_pkg;

  typedef enum logic [1:0] {
    SGN_OFF = 2'b00,
    SGN_POS = 2'b01,
    SGN_NEG = 2'b10
  } sign_e;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam longint PI_Q30  = 64'sd3373259426;
  localparam longint ONE_Q30 = 64'sd1073741824;

  // round(FS*sin(k*pi/(2N))) via a Q30 Taylor series; only evaluated at elaboration.
  function automatic int quarter_sine(input int k, input int msw, input int pw);
    longint x;
    longint term;
    longint sum;
    longint fs;
    x    = (longint'(k) * PI_Q30) / (longint'(2) << msw);
    term = x;
    sum  = x;
    for (int n = 1; n <= 6; n++) begin
      term = -((term * x) / ONE_Q30);
      term = (term * x) / ONE_Q30;
      term = term / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    fs = (longint'(1) << pw) - 1;
    return int'((fs * sum + ONE_Q30 / 2) / ONE_Q30);
  endfunction

endpackage

// File: rtl/stepper_motor_sin_table.sv
// Quarter-wave sine ROM (N+1 entries) with two synchronous read ports.
module stepper_motor_sin_table
  import stepper_motor_pkg::*;
#(
  parameter int MICROSTEP_WIDTH = 8,
  parameter int PWM_WIDTH       = 8
) (
  input  logic                     clk,
  input  logic [MICROSTEP_WIDTH:0] idx_a,
  input  logic [MICROSTEP_WIDTH:0] idx_b,
  output logic [PWM_WIDTH-1:0]     mag_a,
  output logic [PWM_WIDTH-1:0]     mag_b
);

  localparam int N = 1 << MICROSTEP_WIDTH;

  logic [PWM_WIDTH-1:0] sine_rom [0:N];

  for (genvar k = 0; k <= N; k++) begin : g_rom
    localparam logic [PWM_WIDTH-1:0] ENTRY =
      PWM_WIDTH'(quarter_sine(k, MICROSTEP_WIDTH, PWM_WIDTH));
    assign sine_rom[k] = ENTRY;
  end

  always_ff @(posedge clk) begin
    mag_a <= sine_rom[idx_a];
    mag_b <= sine_rom[idx_b];
  end

endmodule

// File: rtl/stepper_motor_microstep_driver.sv
// Position -> two-phase sin/cos PWM H-bridge drive with period-aligned duty updates
// and per-winding dead time on polarity reversal.
module stepper_motor_microstep_driver
  import stepper_motor_pkg::*;
#(
  parameter int MICROSTEP_WIDTH = 8,
  parameter int POS_WIDTH       = 32,
  parameter int PWM_WIDTH       = 8,
  parameter int DEAD_TIME       = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 microstep_en,
  input  logic [POS_WIDTH-1:0] position,
  input  logic [PWM_WIDTH-1:0] current_lim,
  output logic                 period_start,
  output logic                 stm_ap_en,
  output logic                 stm_an_en,
  output logic                 stm_bp_en,
  output logic                 stm_bn_en,
  output logic                 stm_ap_hl,
  output logic                 stm_an_hl,
  output logic                 stm_bp_hl,
  output logic                 stm_bn_hl
);

  localparam int DW = (DEAD_TIME < 1) ? 1 : $clog2(DEAD_TIME + 1);
  localparam logic [PWM_WIDTH-1:0]     FS_V     = '1;
  localparam logic [PWM_WIDTH-1:0]     CNT_LAST = PWM_WIDTH'((1 << PWM_WIDTH) - 2);
  localparam logic [DW-1:0]            DEAD_V   = DW'(DEAD_TIME);
  localparam logic [MICROSTEP_WIDTH:0] N_V      = {1'b1, {MICROSTEP_WIDTH{1'b0}}};

  function automatic logic [PWM_WIDTH-1:0] scale_duty(input logic [PWM_WIDTH-1:0] mag,
                                                      input logic [PWM_WIDTH-1:0] lim);
    logic [2*PWM_WIDTH-1:0] prod;
    prod = mag * lim;
    return prod[2*PWM_WIDTH-1:PWM_WIDTH];
  endfunction

  // Drive word is {p_en, p_hl, n_en, n_hl}.
  function automatic logic [3:0] bridge_drive(input sign_e sgn, input logic on, input logic hold);
    if (hold || sgn == SGN_OFF) return 4'b0000;
    if (!on) return 4'b1010;
    return (sgn == SGN_POS) ? 4'b1110 : 4'b1011;
  endfunction

  function automatic logic need_dead(input logic was_running, input sign_e old_s, input sign_e new_s);
    if (!was_running) return new_s != SGN_OFF;
    return (old_s != SGN_OFF) && (new_s != SGN_OFF) && (old_s != new_s);
  endfunction

  logic [1:0]             quad;
  logic [MICROSTEP_WIDTH:0] frac, frac_c;
  logic                   unused_pos;
  assign quad       = position[MICROSTEP_WIDTH+1:MICROSTEP_WIDTH];
  assign frac       = {1'b0, position[MICROSTEP_WIDTH-1:0]};
  assign frac_c     = N_V - frac;
  assign unused_pos = ^position[POS_WIDTH-1:MICROSTEP_WIDTH+2];

  logic                     vld_p0, vld_p1, vld_p2;
  logic [MICROSTEP_WIDTH:0] idx_a_p0, idx_b_p0;
  sign_e                    sign_a_p0, sign_b_p0, sign_a_p1, sign_b_p1, sign_a_p2, sign_b_p2;
  logic                     full_p0, full_p1;
  logic [PWM_WIDTH-1:0]     mag_a_p1, mag_b_p1, mag_a, mag_b, duty_a_p2, duty_b_p2;

  // Stage p0: angle decode into ROM indices and winding signs
  always_ff @(posedge clk) begin
    idx_a_p0  <= (quad == QUAD_1 || quad == QUAD_3) ? frac : frac_c;
    idx_b_p0  <= (quad == QUAD_1 || quad == QUAD_3) ? frac_c : frac;
    sign_a_p0 <= (quad == QUAD_0 || quad == QUAD_3) ? SGN_POS : SGN_NEG;
    sign_b_p0 <= (quad == QUAD_2 || quad == QUAD_3) ? SGN_NEG : SGN_POS;
    full_p0   <= !microstep_en;
  end

  // Stage p1: sine ROM lookup
  stepper_motor_sin_table #(
    .MICROSTEP_WIDTH(MICROSTEP_WIDTH),
    .PWM_WIDTH      (PWM_WIDTH)
  ) u_sin_table (
    .clk  (clk),
    .idx_a(idx_a_p0),
    .idx_b(idx_b_p0),
    .mag_a(mag_a_p1),
    .mag_b(mag_b_p1)
  );

  always_ff @(posedge clk) begin
    sign_a_p1 <= sign_a_p0;
    sign_b_p1 <= sign_b_p0;
    full_p1   <= full_p0;
  end

  // Stage p2: current scaling; a zero magnitude leaves the winding unpowered
  assign mag_a = full_p1 ? FS_V : mag_a_p1;
  assign mag_b = full_p1 ? FS_V : mag_b_p1;

  always_ff @(posedge clk) begin
    duty_a_p2 <= scale_duty(mag_a, current_lim);
    duty_b_p2 <= scale_duty(mag_b, current_lim);
    sign_a_p2 <= (mag_a == '0) ? SGN_OFF : sign_a_p1;
    sign_b_p2 <= (mag_b == '0) ? SGN_OFF : sign_b_p1;
  end

  logic [PWM_WIDTH-1:0] cnt, cnt_nxt, duty_a, duty_b, duty_a_nxt, duty_b_nxt;
  logic                 running, running_nxt, load;
  sign_e                sgn_a, sgn_b, sgn_a_nxt, sgn_b_nxt;
  logic [DW-1:0]        dead_a, dead_b, dead_a_nxt, dead_b_nxt;
  logic [3:0]           drive_a, drive_b, drive_a_nxt, drive_b_nxt;

  // Active period: duties/signs swap only at the counter wrap (or first cycle after enable)
  always_comb begin
    load        = enable && vld_p2 && (!running || cnt == CNT_LAST);
    cnt_nxt     = cnt;
    running_nxt = running;
    sgn_a_nxt   = sgn_a;
    sgn_b_nxt   = sgn_b;
    duty_a_nxt  = duty_a;
    duty_b_nxt  = duty_b;
    dead_a_nxt  = (dead_a != '0) ? dead_a - 1'b1 : dead_a;
    dead_b_nxt  = (dead_b != '0) ? dead_b - 1'b1 : dead_b;
    if (!enable) begin
      cnt_nxt     = '0;
      running_nxt = 1'b0;
      dead_a_nxt  = '0;
      dead_b_nxt  = '0;
    end else if (load) begin
      cnt_nxt     = '0;
      running_nxt = 1'b1;
      sgn_a_nxt   = sign_a_p2;
      sgn_b_nxt   = sign_b_p2;
      duty_a_nxt  = duty_a_p2;
      duty_b_nxt  = duty_b_p2;
      dead_a_nxt  = need_dead(running, sgn_a, sign_a_p2) ? DEAD_V : '0;
      dead_b_nxt  = need_dead(running, sgn_b, sign_b_p2) ? DEAD_V : '0;
    end else if (running) begin
      cnt_nxt = cnt + 1'b1;
    end
    drive_a_nxt = running_nxt ? bridge_drive(sgn_a_nxt, cnt_nxt < duty_a_nxt, dead_a_nxt != '0) : 4'b0000;
    drive_b_nxt = running_nxt ? bridge_drive(sgn_b_nxt, cnt_nxt < duty_b_nxt, dead_b_nxt != '0) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    duty_a <= duty_a_nxt;
    duty_b <= duty_b_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      cnt          <= '0;
      running      <= 1'b0;
      sgn_a        <= SGN_OFF;
      sgn_b        <= SGN_OFF;
      dead_a       <= '0;
      dead_b       <= '0;
      drive_a      <= 4'b0000;
      drive_b      <= 4'b0000;
      period_start <= 1'b0;
    end else begin
      vld_p0       <= 1'b1;
      vld_p1       <= vld_p0;
      vld_p2       <= vld_p1;
      cnt          <= cnt_nxt;
      running      <= running_nxt;
      sgn_a        <= sgn_a_nxt;
      sgn_b        <= sgn_b_nxt;
      dead_a       <= dead_a_nxt;
      dead_b       <= dead_b_nxt;
      drive_a      <= drive_a_nxt;
      drive_b      <= drive_b_nxt;
      period_start <= load;
    end
  end

  assign {stm_ap_en, stm_ap_hl, stm_an_en, stm_an_hl} = drive_a;
  assign {stm_bp_en, stm_bp_hl, stm_bn_en, stm_bn_hl} = drive_b;

endmodule
